led_scan: RTL

LED_SCAN -- requirements
Module: led_scan

---
 rtl/led_pkg.sv | 19 +
 rtl/led_ascii_dec.sv | 28 ++
 rtl/led_scan.sv | 135 +++++++++++++
 3 files changed

// File: rtl/led_pkg.sv
// Shared constants and types for the multiplexed LED digit scanner.
package led_pkg;

    localparam int BCD_W = 4;

    localparam logic [7:0] ASCII_ZERO  = 8'h30;
    localparam logic [7:0] ASCII_NINE  = 8'h39;
    localparam logic [7:0] ASCII_BS    = 8'h08;
    localparam logic [7:0] ASCII_SPACE = 8'h20;

    // What an incoming character does to the digit buffer.
    typedef enum logic [1:0] {
        CH_IGNORE = 2'd0,
        CH_DIGIT  = 2'd1,
        CH_BS     = 2'd2,
        CH_SPACE  = 2'd3
    } char_class_t;

endpackage

// File: rtl/led_ascii_dec.sv
// Combinational ASCII classifier: digit / backspace / space / ignore, plus BCD value.
module led_ascii_dec
    import led_pkg::*;
(
    input  logic [7:0]       wr_data,
    output char_class_t      char_class,
    output logic [BCD_W-1:0] bcd
);

    logic [7:0] offset;

    assign offset = wr_data - ASCII_ZERO;

    // Classify the character; BCD is only meaningful for the digit class.
    always_comb begin
        char_class = CH_IGNORE;
        bcd        = '0;
        if (wr_data >= ASCII_ZERO && wr_data <= ASCII_NINE) begin
            char_class = CH_DIGIT;
            bcd        = offset[BCD_W-1:0];
        end else if (wr_data == ASCII_BS) begin
            char_class = CH_BS;
        end else if (wr_data == ASCII_SPACE) begin
            char_class = CH_SPACE;
        end
    end

endmodule

// File: rtl/led_scan.sv
// Multiplexed seven-segment scanner: character buffer, prescaler, scan index
// and registered digit/select outputs.
module led_scan
    import led_pkg::*;
#(
    parameter int DIGITS   = 4,
    parameter int SCAN_DIV = 1000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [7:0]        wr_data,
    input  logic              clr,
    output logic [3:0]        dbus,
    output logic [DIGITS-1:0] sbus,
    output logic              blank
);

    localparam int PW = $clog2(SCAN_DIV);
    localparam int IW = $clog2(DIGITS);

    char_class_t      dec_class;
    logic [BCD_W-1:0] dec_bcd;

    logic [BCD_W-1:0] bcd_reg [DIGITS];
    logic [DIGITS-1:0] valid_reg;

    // Per-entry sources for a shift up (towards the top) and a shift down.
    logic [BCD_W-1:0] up_bcd [DIGITS];
    logic [DIGITS-1:0] up_valid;
    logic [BCD_W-1:0] dn_bcd [DIGITS];
    logic [DIGITS-1:0] dn_valid;

    logic [PW-1:0] presc_reg;
    logic [IW-1:0] idx_reg;
    logic          scan_tick;

    logic [3:0]        dbus_reg;
    logic [DIGITS-1:0] sbus_reg;
    logic              blank_reg;

    led_ascii_dec u_dec (
        .wr_data    (wr_data),
        .char_class (dec_class),
        .bcd        (dec_bcd)
    );

    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : gen_entry
            if (gi == 0) begin : gen_bottom
                assign up_bcd[gi]   = dec_bcd;
                assign up_valid[gi] = 1'b1;
            end else begin : gen_mid_up
                assign up_bcd[gi]   = bcd_reg[gi-1];
                assign up_valid[gi] = valid_reg[gi-1];
            end
            if (gi == DIGITS-1) begin : gen_top
                assign dn_bcd[gi]   = '0;
                assign dn_valid[gi] = 1'b0;
            end else begin : gen_mid_dn
                assign dn_bcd[gi]   = bcd_reg[gi+1];
                assign dn_valid[gi] = valid_reg[gi+1];
            end
        end
    endgenerate

    // Digit buffer: clear beats any write; space inserts an empty slot at 0;
    // backspace on an already empty buffer leaves it untouched.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < DIGITS; k++) bcd_reg[k] <= '0;
            valid_reg <= '0;
        end else if (clr) begin
            for (int k = 0; k < DIGITS; k++) bcd_reg[k] <= '0;
            valid_reg <= '0;
        end else if (wr_en) begin
            case (dec_class)
                CH_DIGIT: begin
                    for (int k = 0; k < DIGITS; k++) bcd_reg[k] <= up_bcd[k];
                    valid_reg <= up_valid;
                end
                CH_SPACE: begin
                    for (int k = 1; k < DIGITS; k++) bcd_reg[k] <= up_bcd[k];
                    bcd_reg[0] <= '0;
                    valid_reg  <= {up_valid[DIGITS-1:1], 1'b0};
                end
                CH_BS: begin
                    if (|valid_reg) begin
                        for (int k = 0; k < DIGITS; k++) bcd_reg[k] <= dn_bcd[k];
                        valid_reg <= dn_valid;
                    end
                end
                default: ;
            endcase
        end
    end

    assign scan_tick = (presc_reg == PW'(SCAN_DIV - 1));

    // Prescaler and scan index; the index steps on each terminal count.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            presc_reg <= '0;
            idx_reg   <= '0;
        end else if (scan_tick) begin
            presc_reg <= '0;
            idx_reg   <= (idx_reg == IW'(DIGITS - 1)) ? '0 : idx_reg + 1'b1;
        end else begin
            presc_reg <= presc_reg + 1'b1;
        end
    end

    // Registered outputs: at most one select line low, only for a valid entry.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sbus_reg  <= '1;
            dbus_reg  <= '0;
            blank_reg <= 1'b1;
        end else if (valid_reg[idx_reg]) begin
            sbus_reg  <= ~(DIGITS'(1) << idx_reg);
            dbus_reg  <= bcd_reg[idx_reg];
            blank_reg <= 1'b0;
        end else begin
            sbus_reg  <= '1;
            dbus_reg  <= '0;
            blank_reg <= 1'b1;
        end
    end

    assign dbus  = dbus_reg;
    assign sbus  = sbus_reg;
    assign blank = blank_reg;

endmodule
